sum_accumulator: RTL and testbench

Parametrised multi-operand adder. It is the successor to the single-shot 8-bit sum design. The block accepts a stream of WIDTH-bit operands over a valid/ready handshake and accumulates them until a last-flagged operand arrives or MAX_OPS operands have been taken. It then presents the sum with sticky carry/overflow flags and holds it until the consumer accepts it. Unsigned/signed and wrap/saturate arithmetic are selectable per packet. It sits behind the top-level pin wrapper: operands come from dedicated inputs and results go to dedicated outputs.

---
 rtl/sum_accumulator_if.sv | 29 ++
 rtl/sum_accumulator.sv | 97 +++++++++
 tb/tb_sum_accumulator.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sum_accumulator_if.sv
// Operand/result handshake bundle for sum_accumulator.
// The slave side is the accumulator; the master side feeds operands and takes results.
interface sum_accumulator_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             mode_signed;
  logic             mode_sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_overflow;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_data, in_last, mode_signed, mode_sat, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_overflow, out_count
  );

  modport master (
    output in_valid, in_data, in_last, mode_signed, mode_sat, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_overflow, out_count
  );
endinterface

// File: rtl/sum_accumulator.sv
// Streaming multi-operand adder: accumulates operands into one packet sum with
// sticky carry/overflow, unsigned/signed and wrap/saturate chosen on the first operand.
module sum_accumulator #(
  parameter  int WIDTH   = 8,
  parameter  int MAX_OPS = 16,
  localparam int CNT_W   = $clog2(MAX_OPS + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clear,
  sum_accumulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             carry_q;
  logic             ovf_q;
  logic             sgn_q;
  logic             sat_q;

  logic [WIDTH:0]   sum_x;
  logic [WIDTH-1:0] add_res;
  logic             add_c;
  logic             add_v;
  logic             at_max;

  localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Events are only reported for the arithmetic actually selected, so the
  // sticky flags need no further masking at the output.
  always_comb begin
    sum_x   = {1'b0, acc} + {1'b0, bus.in_data};
    add_c   = !sgn_q && sum_x[WIDTH];
    add_v   = sgn_q && (acc[WIDTH-1] == bus.in_data[WIDTH-1])
                    && (sum_x[WIDTH-1] != acc[WIDTH-1]);
    add_res = sum_x[WIDTH-1:0];
    if (sat_q && add_c) add_res = '1;
    if (sat_q && add_v) add_res = acc[WIDTH-1] ? S_MIN : S_MAX;
  end

  assign at_max = (count == CNT_W'(MAX_OPS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      sgn_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else if (ena) begin
      if (clear) begin
        state   <= IDLE;
        acc     <= '0;
        count   <= '0;
        carry_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.in_valid) begin
            acc     <= bus.in_data;
            count   <= CNT_W'(1);
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            sgn_q   <= bus.mode_signed;
            sat_q   <= bus.mode_sat;
            state   <= (bus.in_last || MAX_OPS == 1) ? DONE : ACCUM;
          end
          ACCUM: if (bus.in_valid) begin
            acc     <= add_res;
            count   <= count + CNT_W'(1);
            carry_q <= carry_q | add_c;
            ovf_q   <= ovf_q | add_v;
            state   <= (bus.in_last || at_max) ? DONE : ACCUM;
          end
          DONE: if (bus.out_ready) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Handshake outputs depend only on state and ena, never on the peer's strobes.
  assign bus.in_ready     = ena && (state != DONE);
  assign bus.out_valid    = ena && (state == DONE);
  assign bus.out_sum      = acc;
  assign bus.out_carry    = carry_q;
  assign bus.out_overflow = ovf_q;
  assign bus.out_count    = count;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboarded bench for sum_accumulator: directed scenarios plus random packets
// checked against an integer-arithmetic packet model.
module tb_sum_accumulator;
  localparam int W  = 8;
  localparam int MO = 4;
  localparam int CW = $clog2(MO + 1);
  localparam int UMAX = (1 << W) - 1;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic clear = 1'b0;

  sum_accumulator_if #(.WIDTH(W), .CNT_W(CW)) bus();

  sum_accumulator #(.WIDTH(W), .MAX_OPS(MO)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { int sum; bit c; bit v; int cnt; } exp_t;
  exp_t q[$];
  exp_t last_exp;

  int  n_pass = 0;
  int  n_total = 0;
  bit  hold_bp = 1'b0;

  bit  in_pkt = 1'b0;
  int  m_acc, m_cnt;
  bit  m_c, m_v, m_sgn, m_sat;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference add on plain integers: true mathematical sum, then wrap or clamp.
  function automatic void model_add(input int a, input int b, input bit sgn, input bit sat,
                                    output int r, output bit c, output bit v);
    int s, sa, sb;
    c = 1'b0; v = 1'b0;
    if (!sgn) begin
      s = a + b;
      c = (s > UMAX);
      r = c ? (sat ? UMAX : s - (UMAX + 1)) : s;
    end else begin
      sa = (a > SMAX) ? a - (UMAX + 1) : a;
      sb = (b > SMAX) ? b - (UMAX + 1) : b;
      s  = sa + sb;
      v  = (s > SMAX) || (s < SMIN);
      if (sat && v) r = (s > SMAX) ? SMAX : SMIN;
      else          r = s;
      r = (r < 0) ? r + (UMAX + 1) : r % (UMAX + 1);
    end
  endfunction

  function automatic bit model_accept(input int d, input bit last, input bit sgn, input bit sat);
    int r; bit c, v;
    exp_t e;
    if (!in_pkt) begin
      in_pkt = 1'b1; m_acc = d; m_cnt = 1; m_c = 0; m_v = 0; m_sgn = sgn; m_sat = sat;
    end else begin
      model_add(m_acc, d, m_sgn, m_sat, r, c, v);
      m_acc = r; m_c |= c; m_v |= v; m_cnt++;
    end
    if (last || m_cnt == MO) begin
      e.sum = m_acc; e.c = m_c; e.v = m_v; e.cnt = m_cnt;
      q.push_back(e);
      last_exp = e;
      in_pkt = 1'b0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic send_op(input int d, input bit last, input bit sgn, input bit sat);
    bit took; int guard; bit fin;
    bus.in_data = d[W-1:0]; bus.in_last = last;
    bus.mode_signed = sgn; bus.mode_sat = sat; bus.in_valid = 1'b1;
    took = 1'b0; guard = 0;
    while (!took && guard < 200) begin
      @(negedge clk);
      took = bus.in_ready && ena && !clear;
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (!took) begin
      check("accept_timeout", 0, 1);
      return;
    end
    fin = model_accept(d, last, sgn, sat);
    if (fin) check("latency_out_valid", bus.out_valid, 1);
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 300) begin
      @(posedge clk); #1; guard++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_sum"}, bus.out_sum, 0);
    check({tag, "_carry"}, bus.out_carry, 0);
    check({tag, "_ovf"}, bus.out_overflow, 0);
    check({tag, "_count"}, bus.out_count, 0);
  endtask

  // Consumer: random acceptance unless a directed test is holding backpressure.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.out_ready = hold_bp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every result handshake pops one expected packet.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) check("unexpected_result", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("sum", bus.out_sum, e.sum);
        check("carry", bus.out_carry, e.c);
        check("overflow", bus.out_overflow, e.v);
        check("count", bus.out_count, e.cnt);
      end
    end
  end

  initial begin
    bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0;
    bus.mode_signed = 0; bus.mode_sat = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1; ena = 1'b1;
    #1 check("in_ready_idle", bus.in_ready, 1);

    // unsigned wrap, no carry
    send_op(100, 0, 0, 0); send_op(50, 0, 0, 0); send_op(30, 1, 0, 0);
    drain();
    // unsigned carry, wrap then saturate
    send_op(200, 0, 0, 0); send_op(100, 1, 0, 0);
    send_op(200, 0, 0, 1); send_op(100, 1, 0, 1);
    drain();
    // signed saturate, both directions
    send_op(8'h70, 0, 1, 1); send_op(8'h20, 1, 1, 1);
    send_op(8'h80, 0, 1, 1); send_op(8'hFF, 1, 1, 1);
    drain();

    // MAX_OPS forces end of packet; the rest start a new packet
    for (int i = 0; i < 4; i++) send_op(1, 0, 0, 0);
    check("in_ready_done", bus.in_ready, 0);
    send_op(1, 0, 0, 0); send_op(1, 0, 0, 0); send_op(1, 1, 0, 0);
    drain();

    // backpressure holds the result
    hold_bp = 1'b1;
    send_op(10, 0, 0, 0); send_op(20, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", bus.out_valid, 1);
      check("bp_sum", bus.out_sum, last_exp.sum);
      check("bp_in_ready", bus.in_ready, 0);
    end
    hold_bp = 1'b0;
    drain();

    // mid-packet clear drops the same-cycle operand
    send_op(7, 0, 0, 0); send_op(8, 0, 0, 0);
    clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'd99; bus.in_last = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; bus.in_valid = 1'b0; in_pkt = 1'b0;
    check("clear_count", bus.out_count, 0);
    check("clear_sum", bus.out_sum, 0);
    check("clear_valid", bus.out_valid, 0);
    send_op(3, 0, 0, 0); send_op(4, 1, 0, 0);
    drain();

    // ena low freezes everything
    send_op(5, 0, 0, 0); send_op(6, 0, 0, 0);
    ena = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'd77; bus.in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("ena_in_ready", bus.in_ready, 0);
      check("ena_count", bus.out_count, 2);
      check("ena_sum", bus.out_sum, 11);
    end
    bus.in_valid = 1'b0; ena = 1'b1;
    send_op(1, 1, 0, 0);
    drain();

    // reset mid-packet
    send_op(9, 0, 0, 0); send_op(9, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_zero("midrst");
    rst_n = 1'b1; in_pkt = 1'b0;
    send_op(5, 0, 0, 0); send_op(6, 1, 0, 0);
    drain();

    // random packets; mode inputs toggle on every operand
    for (int i = 0; i < 60; i++)
      send_op($urandom_range(0, UMAX), $urandom_range(0, 3) == 0,
              $urandom_range(0, 1), $urandom_range(0, 1));
    send_op($urandom_range(0, UMAX), 1, 0, 0);
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
